// File: rtl/cic_interpolator.sv
//==============================================================================
// Module      : cic_interpolator
// Description : N-stage CIC interpolator: low-rate combs, zero-stuff by RATE,
//               high-rate pipelined integrators, valid/ready on both sides.
//               Optional macro CIC_INTERP_ROUND_EN selects round-half-up output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cic_interpolator #(
  parameter int DATA_IN_WIDTH      = 12,
  parameter int ACC_WIDTH          = 24,
  parameter int DATA_OUT_WIDTH     = 20,
  parameter int NUM_STAGES         = 3,
  parameter int RATE               = 4,
  parameter int DIFFERENTIAL_DELAY = 1,
  parameter int OUT_SHIFT          = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic                      m_first
);

  localparam int              PH_W    = $clog2(RATE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE - 1);
`ifdef CIC_INTERP_ROUND_EN
  localparam logic [ACC_WIDTH-1:0] RND = ACC_WIDTH'((64'd1 << OUT_SHIFT) >> 1);
`endif

  logic [PH_W-1:0]           phase_q, phase_d;
  logic                      m_valid_q, m_valid_d;
  logic                      m_first_q, m_first_d;
  logic [DATA_OUT_WIDTH-1:0] m_data_q, m_data_d;

  logic signed [ACC_WIDTH-1:0] dly_q   [NUM_STAGES][DIFFERENTIAL_DELAY];
  logic signed [ACC_WIDTH-1:0] comb_in [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_q [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_out;
  logic signed [ACC_WIDTH-1:0] upsamp;
  logic signed [ACC_WIDTH-1:0] out_acc;

  logic out_free;
  logic at_zero;
  logic adv;
  logic accept;

  // The whole chain moves only when the output register can take a new beat.
  assign out_free = !m_valid_q || m_ready;
  assign at_zero  = (phase_q == '0);
  assign adv      = out_free && (!at_zero || s_valid);
  assign accept   = adv && at_zero;
  assign s_ready  = at_zero && out_free;

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_first  = m_first_q;

  always_comb begin
    comb_out = {{(ACC_WIDTH-DATA_IN_WIDTH){s_data[DATA_IN_WIDTH-1]}}, s_data};
    for (int k = 0; k < NUM_STAGES; k++) begin
      comb_in[k] = comb_out;
      comb_out   = comb_out - dly_q[k][DIFFERENTIAL_DELAY-1];
    end
    upsamp = at_zero ? comb_out : '0;
  end

  always_comb begin
    // Integrators are pipelined: each stage adds the previous stage's registered value.
    integ_d[0] = integ_q[0] + upsamp;
    for (int k = 1; k < NUM_STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
`ifdef CIC_INTERP_ROUND_EN
    out_acc = integ_d[NUM_STAGES-1] + RND;
`else
    out_acc = integ_d[NUM_STAGES-1];
`endif
    phase_d   = phase_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    if (adv) begin
      phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      m_valid_d = 1'b1;
      m_data_d  = DATA_OUT_WIDTH'(out_acc >>> OUT_SHIFT);
      m_first_d = at_zero;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_first_q <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < DIFFERENTIAL_DELAY; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else begin
      phase_q   <= phase_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      if (adv) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          integ_q[k] <= integ_d[k];
        end
      end
      // Comb delay lines see only accepted low-rate samples, never stuffed zeros.
      if (accept) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          dly_q[k][0] <= comb_in[k];
          for (int j = 1; j < DIFFERENTIAL_DELAY; j++) begin
            dly_q[k][j] <= dly_q[k][j-1];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cic_interpolator.sv
//==============================================================================
// Module      : tb_cic_interpolator
// Description : Scoreboard bench for cic_interpolator over three configurations.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cic_interpolator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sv [3];
  logic [11:0] sd [3];
  logic        mr [3];
  logic        sr [3];
  logic        mv [3];
  logic [19:0] md [3];
  logic        mf [3];

  typedef struct packed {
    logic [1:0]  d;
    logic [19:0] v;
    logic        f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   t2 [16];

  // dut0: N=1 SHIFT=0, dut1: N=3 SHIFT=4, dut2: N=1 SHIFT=1; all R=4 M=1
  cic_interpolator #(.NUM_STAGES(1), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .m_first(mf[0]));
  cic_interpolator #(.NUM_STAGES(3), .OUT_SHIFT(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .m_first(mf[1]));
  cic_interpolator #(.NUM_STAGES(1), .OUT_SHIFT(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .m_first(mf[2]));

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: a beat retires on the next edge when m_valid && m_ready
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (reset_n && mv[i] && mr[i]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected dut%0d: got data %0d, no beat expected", i, $signed(md[i]));
        end else begin
          e = q.pop_front();
          checks++;
          if (int'(e.d) != i || md[i] != e.v) begin
            errors++;
            $display("FAIL beat_data dut%0d: got %0d, expected dut%0d value %0d",
                     i, $signed(md[i]), e.d, $signed(e.v));
          end
          checks++;
          if (mf[i] != e.f) begin
            errors++;
            $display("FAIL beat_first dut%0d: got %0b, expected %0b", i, mf[i], e.f);
          end
        end
      end
    end
  end

  // Offer one sample; push its RATE expected beats when it is accepted.
  task automatic feed(input int d, input int x, input int ev[4], input int exp_wait);
    int waits;
    sd[d] = 12'(x);
    sv[d] = 1'b1;
    #1;
    waits = 0;
    while (!sr[d] && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!sr[d]) begin
      check("s_ready_timeout", 0, 1);
    end else begin
      if (exp_wait >= 0) check("s_ready_spacing", waits, exp_wait);
      for (int j = 0; j < 4; j++) q.push_back('{d: 2'(d), v: 20'(ev[j]), f: (j == 0)});
      @(posedge clk); #1;
    end
    sv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_m_valid"}, int'(mv[d]), 0);
    check({tag, "_s_ready"}, int'(sr[d]), 1);
  endtask

  initial begin
`ifdef CIC_INTERP_ROUND_EN
    t2 = '{0, 0, 6, 19, 38, 63, 81, 94, 100, 100, 100, 100, 100, 100, 100, 100};
`else
    t2 = '{0, 0, 6, 18, 37, 62, 81, 93, 100, 100, 100, 100, 100, 100, 100, 100};
`endif
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
      mr[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      check("rst_m_valid", int'(mv[i]), 0);
      check("rst_m_data", int'(md[i]), 0);
      check("rst_m_first", int'(mf[i]), 0);
      check("rst_s_ready", int'(sr[i]), 1);
    end

    // Impulse response of a single-stage interpolator is a hold of RATE beats
    feed(0, 5, '{5, 5, 5, 5}, -1);
    feed(0, 0, '{0, 0, 0, 0}, 3);
    drain();
    check_idle(0, "underrun1");

    // Backpressure for three cycles right after a new beat appears
    feed(0, 7, '{7, 7, 7, 7}, -1);
    mr[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_m_data", $signed(md[0]), 7);
      check("bp_m_first", int'(mf[0]), 1);
      check("bp_m_valid", int'(mv[0]), 1);
      check("bp_s_ready", int'(sr[0]), 0);
    end
    mr[0] = 1'b1;
    feed(0, 2, '{2, 2, 2, 2}, 3);
    drain();
    check_idle(0, "underrun2");
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "underrun3");

    // Reset in the middle of a burst drops pending beats
    feed(0, 9, '{9, 9, 9, 9}, -1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete();
    check("mid_rst_m_valid", int'(mv[0]), 0);
    check("mid_rst_m_data", int'(md[0]), 0);
    check("mid_rst_m_first", int'(mf[0]), 0);
    check("mid_rst_s_ready", int'(sr[0]), 1);
    feed(0, 5, '{5, 5, 5, 5}, -1);
    feed(0, 0, '{0, 0, 0, 0}, 3);
    drain();

    // Three-stage DC step: gain (4*1)^3/4 = 16, removed by the shift of 4
    for (int s = 0; s < 4; s++) begin
      feed(1, 100, '{t2[4*s], t2[4*s+1], t2[4*s+2], t2[4*s+3]}, (s == 0) ? -1 : 3);
    end
    drain();

    // Output shift of 1 on odd values: truncate vs round-half-up
`ifdef CIC_INTERP_ROUND_EN
    feed(2, 3, '{2, 2, 2, 2}, -1);
    feed(2, -3, '{-1, -1, -1, -1}, 3);
`else
    feed(2, 3, '{1, 1, 1, 1}, -1);
    feed(2, -3, '{-2, -2, -2, -2}, 3);
`endif
    feed(2, 0, '{0, 0, 0, 0}, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
